// File: rtl/stepper_pkg.sv
// Shared types and defaults for the stepper pulse controller.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_t;

  localparam logic MODE_PROFILE = 1'b0;
  localparam logic MODE_CONST   = 1'b1;

  localparam int DEF_PER_W    = 32;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_POS_W    = 32;
  localparam int DEF_PULSE_HI = 4;

endpackage

// File: rtl/step_pulse_gen.sv
// One step: counts 0..period-1 after load, STEP high for the first PULSE_HI counts.
// step_end marks the last count cycle; kill drops the pulse and the count at once.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int PER_W    = DEF_PER_W,
  parameter int PULSE_HI = DEF_PULSE_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PER_W-1:0] period,
  input  logic             kill,
  output logic             pul_out,
  output logic             step_end
);

  localparam logic [PER_W-1:0] HI_CNT = PER_W'(PULSE_HI);

  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_q;
  logic             active;

  assign step_end = active && (cnt == per_q - PER_W'(1));

  // pul_out is registered so the driver pin never sees combinational glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      per_q   <= '0;
      active  <= 1'b0;
      pul_out <= 1'b0;
    end else if (kill) begin
      cnt     <= '0;
      active  <= 1'b0;
      pul_out <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      per_q   <= period;
      active  <= 1'b1;
      pul_out <= 1'b1;
    end else if (active) begin
      if (step_end) begin
        cnt     <= '0;
        active  <= 1'b0;
        pul_out <= 1'b0;
      end else begin
        cnt     <= cnt + PER_W'(1);
        pul_out <= (cnt + PER_W'(1)) < HI_CNT;
      end
    end
  end

endmodule

// File: rtl/stepper_profile_ctrl.sv
// Single-axis STEP/DIR controller: streamed-period profile or constant-velocity moves,
// with pause, abort, stream-underflow flag and signed position tracking.
module stepper_profile_ctrl
  import stepper_pkg::*;
#(
  parameter int PER_W    = DEF_PER_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int POS_W    = DEF_POS_W,
  parameter int PULSE_HI = DEF_PULSE_HI
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [CNT_W-1:0]        total_steps,
  input  logic [CNT_W-1:0]        accel_end,
  input  logic [CNT_W-1:0]        decel_begin,
  input  logic [PER_W-1:0]        const_period,
  input  logic                    dir,
  input  logic                    pause,
  input  logic                    abort,
  input  logic                    pos_clr,
  input  logic [PER_W-1:0]        per_tdata,
  input  logic                    per_tvalid,
  output logic                    per_tready,
  output logic                    pul_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        step_cnt,
  output logic signed [POS_W-1:0] position,
  output logic [PER_W-1:0]        cur_period,
  output logic                    err_underflow
);

  localparam logic [PER_W-1:0] MIN_PER = PER_W'(PULSE_HI + 1);

  state_t           state, state_d;
  logic             mode_q;
  logic [CNT_W-1:0] total_q, accel_q, decel_q, step_inc;
  logic [PER_W-1:0] const_q, new_per;
  logic             ramp_down, cruise, need_word, last_step, load, step_end;

  function automatic logic [PER_W-1:0] clamp_per(input logic [PER_W-1:0] p);
    return (p < MIN_PER) ? MIN_PER : p;
  endfunction

  assign busy      = (state != ST_IDLE);
  assign step_inc  = step_cnt + CNT_W'(1);
  assign last_step = (step_inc == total_q);

  // RAMP_DOWN wins when accel_end > decel_begin, leaving CRUISE empty
  assign ramp_down = (step_cnt >= decel_q);
  assign cruise    = !ramp_down && (step_cnt >= accel_q);
  // a move that starts in CRUISE still needs one word to seed cur_period
  assign need_word  = (mode_q == MODE_PROFILE) && (!cruise || step_cnt == '0);
  assign per_tready = (state == ST_LOAD) && need_word && !abort;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    new_per = cur_period;
    unique case (state)
      ST_IDLE: begin
        if (start && total_steps != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (mode_q == MODE_CONST) begin
          new_per = clamp_per(const_q);
          load    = 1'b1;
        end else if (!need_word) begin
          load = 1'b1;
        end else if (per_tvalid) begin
          new_per = clamp_per(per_tdata);
          load    = 1'b1;
        end
        if (load) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step_end) begin
          if (last_step)  state_d = ST_IDLE;
          else if (pause) state_d = ST_PAUSE;
          else            state_d = ST_LOAD;
        end
      end
      ST_PAUSE: begin
        if (!pause) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_PROFILE;
      dir_out       <= 1'b0;
      total_q       <= '0;
      accel_q       <= '0;
      decel_q       <= '0;
      const_q       <= '0;
      step_cnt      <= '0;
      position      <= '0;
      cur_period    <= '0;
      err_underflow <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      // abort freezes counters: a partially emitted step is never counted
      if (!abort) begin
        if (state == ST_IDLE && start) begin
          if (total_steps == '0) begin
            done <= 1'b1;
          end else begin
            mode_q        <= mode;
            dir_out       <= dir;
            total_q       <= total_steps;
            accel_q       <= accel_end;
            decel_q       <= decel_begin;
            const_q       <= const_period;
            step_cnt      <= '0;
            err_underflow <= 1'b0;
          end
        end
        if (load) cur_period <= new_per;
        if (per_tready && !per_tvalid) err_underflow <= 1'b1;
        if (state == ST_RUN && step_end) begin
          step_cnt <= step_inc;
          position <= dir_out ? position + POS_W'(1) : position - POS_W'(1);
          if (last_step) done <= 1'b1;
        end
      end
      if (pos_clr) position <= '0;
    end
  end

  step_pulse_gen #(
    .PER_W    (PER_W),
    .PULSE_HI (PULSE_HI)
  ) u_pulse (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .period   (new_per),
    .kill     (abort),
    .pul_out  (pul_out),
    .step_end (step_end)
  );

endmodule

// File: tb/tb_stepper_profile_ctrl.sv
// Directed bench for stepper_profile_ctrl: a step-list model predicts per-step periods and
// rise-to-rise spacing; one per-cycle monitor checks pulses, stream use and invariants.
module tb_stepper_profile_ctrl;

  localparam int PER_W    = 32;
  localparam int CNT_W    = 32;
  localparam int POS_W    = 32;
  localparam int PULSE_HI = 4;

  logic                    clk, rst_n, start, mode, dir, pause, abort, pos_clr;
  logic [CNT_W-1:0]        total_steps, accel_end, decel_begin;
  logic [PER_W-1:0]        const_period, per_tdata;
  logic                    per_tvalid, per_tready, pul_out, dir_out, busy, done, err_underflow;
  logic [CNT_W-1:0]        step_cnt;
  logic signed [POS_W-1:0] position;
  logic [PER_W-1:0]        cur_period;

  stepper_profile_ctrl #(
    .PER_W(PER_W), .CNT_W(CNT_W), .POS_W(POS_W), .PULSE_HI(PULSE_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .total_steps(total_steps),
    .accel_end(accel_end), .decel_begin(decel_begin), .const_period(const_period),
    .dir(dir), .pause(pause), .abort(abort), .pos_clr(pos_clr),
    .per_tdata(per_tdata), .per_tvalid(per_tvalid), .per_tready(per_tready),
    .pul_out(pul_out), .dir_out(dir_out), .busy(busy), .done(done),
    .step_cnt(step_cnt), .position(position), .cur_period(cur_period),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_fails, cyc;
  // stream source
  int s_words[16];
  int s_len, s_idx, gap_at, gap_len, stall;
  bit hs_prev;
  // model expectations and monitor state
  int exp_per[16];
  int exp_int[16];
  int n_exp, exp_words, per_idx, int_idx, prev_rise, rises, done_cnt, hi_len;
  bit int_chk, prev_pul, prev_done, exp_dir;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Step list from the move rules: which steps fetch a word, each step's clamped period,
  // and the rise-to-rise spacing (period + 1 LOAD cycle, stretched by a stream gap).
  function automatic int build_model(input bit md, input int cp, input int total,
                                     input int ae, input int db);
    int w = 0;
    int per = 0;
    bit down, up, fetch, gapped;
    for (int k = 0; k < total; k++) begin
      down   = (k >= db);
      up     = !down && (k < ae);
      fetch  = !md && (down || up || k == 0);
      gapped = 1'b0;
      if (md) per = cp;
      else if (fetch) begin
        gapped = (w == gap_at);
        per    = s_words[w];
        w++;
      end
      if (per < PULSE_HI + 1) per = PULSE_HI + 1;
      exp_per[k] = per;
      if (k > 0)
        exp_int[k-1] = ((gapped && gap_len > exp_per[k-1]) ? gap_len : exp_per[k-1]) + 1;
    end
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hs_prev) begin
      s_idx++;
      if (s_idx == gap_at) stall = gap_len;
    end else if (stall > 0) begin
      stall--;
    end
    per_tvalid = (s_idx < s_len) && (stall == 0);
    per_tdata  = per_tvalid ? PER_W'(s_words[s_idx]) : '0;
    hs_prev    = per_tvalid && per_tready;

    if (pul_out && !prev_pul) begin
      rises++;
      check("pulse_budget", per_idx < n_exp, 1);
      if (per_idx < n_exp) begin
        check("cur_period", cur_period, exp_per[per_idx]);
        per_idx++;
      end
      if (int_chk && prev_rise >= 0 && int_idx < n_exp - 1) begin
        check("step_interval", cyc - prev_rise, exp_int[int_idx]);
        int_idx++;
      end
      prev_rise = cyc;
    end
    if (pul_out) hi_len++;
    else if (prev_pul) begin
      if (busy) check("pulse_high_cycles", hi_len, PULSE_HI);
      hi_len = 0;
    end
    if (done) begin
      done_cnt++;
      check("done_one_cycle", prev_done, 0);
    end
    check("no_pulse_when_idle", pul_out && !busy, 0);
    check("no_tready_when_idle", per_tready && !busy, 0);
    if (busy) check("dir_latched", dir_out, exp_dir);
    prev_pul  = pul_out;
    prev_done = done;
  endtask

  task automatic setup_move(input bit md, input int cp, input int total, input int ae,
                            input int db, input bit dr, input bit chk_int);
    mode         = md;
    const_period = PER_W'(cp);
    total_steps  = CNT_W'(total);
    accel_end    = CNT_W'(ae);
    decel_begin  = CNT_W'(db);
    dir          = dr;
    exp_dir      = dr;
    s_idx        = 0;
    stall        = 0;
    hs_prev      = 1'b0;
    n_exp        = total;
    exp_words    = build_model(md, cp, total, ae, db);
    per_idx      = 0;
    int_idx      = 0;
    prev_rise    = -1;
    rises        = 0;
    int_chk      = chk_int;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("move_finished", busy, 0);
    check("done_at_finish", done, 1);
    check("pulse_count", rises, n_exp);
  endtask

  task automatic wait_rises(input int n, input int max);
    int k = 0;
    while (rises < n && k < max) begin
      tick();
      k++;
    end
    check("rise_wait", rises, n);
  endtask

  initial begin
    int lit[8] = '{40, 30, 20, 20, 20, 20, 30, 40};
    int pos0, d0;
    n_checks = 0; n_fails = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; dir = 1'b0; pause = 1'b0; abort = 1'b0;
    pos_clr = 1'b0; total_steps = '0; accel_end = '0; decel_begin = '0;
    const_period = '0; per_tdata = '0; per_tvalid = 1'b0;
    s_len = 0; s_idx = 0; gap_at = -1; gap_len = 0; stall = 0; hs_prev = 1'b0;
    n_exp = 0; exp_words = 0; per_idx = 0; int_idx = 0; prev_rise = -1; rises = 0;
    done_cnt = 0; hi_len = 0; int_chk = 1'b0; prev_pul = 1'b0; prev_done = 1'b0; exp_dir = 1'b0;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_pul", pul_out, 0);
    check("rst_done", done, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_position", position, 0);
    check("rst_cur_period", cur_period, 0);
    check("rst_err", err_underflow, 0);
    check("rst_tready", per_tready, 0);
    check("rst_dir_out", dir_out, 0);
    rst_n = 1'b1;
    tick();

    // constant mode, 5 steps forward; a start mid-move must be ignored
    d0 = done_cnt;
    setup_move(1'b1, 10, 5, 0, 0, 1'b1, 1'b1);
    check("t1_model_interval", exp_int[0], 11);
    repeat (20) tick();
    total_steps = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(500);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_position", position, 5);
    check("t1_step_cnt", step_cnt, 5);
    check("t1_err", err_underflow, 0);

    // profile: 3 ramp-up words, 2 cruise steps reuse 20, 3 ramp-down words
    s_words[0:5] = '{40, 30, 20, 20, 30, 40};
    s_len = 6; gap_at = -1;
    setup_move(1'b0, 0, 8, 3, 5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) check("t2_model_period", exp_per[i], lit[i]);
    check("t2_model_words", exp_words, 6);
    wait_idle(2000);
    check("t2_words_consumed", s_idx, 6);
    check("t2_position", position, 13);
    check("t2_step_cnt", step_cnt, 8);
    check("t2_err", err_underflow, 0);

    // stream stalls 50 cycles before the second word
    s_words[0:3] = '{20, 20, 20, 20};
    s_len = 4; gap_at = 1; gap_len = 50;
    setup_move(1'b0, 0, 4, 4, 4, 1'b0, 1'b1);
    check("t3_model_gap", exp_int[0], 51);
    wait_idle(2000);
    check("t3_words_consumed", s_idx, 4);
    check("t3_position", position, 9);
    check("t3_err_set", err_underflow, 1);
    repeat (3) tick();
    check("t3_err_sticky", err_underflow, 1);

    // pause mid step 2 of 6 for 100 cycles
    s_len = 0; gap_at = -1; gap_len = 0;
    pos0 = position;
    setup_move(1'b1, 10, 6, 0, 0, 1'b1, 1'b0);
    tick();
    check("t4_err_cleared", err_underflow, 0);
    wait_rises(2, 100);
    repeat (3) tick();
    pause = 1'b1;
    repeat (100) tick();
    check("t4_pause_rises", rises, 2);
    check("t4_pause_step_cnt", step_cnt, 2);
    check("t4_pause_busy", busy, 1);
    check("t4_pause_pul", pul_out, 0);
    pause = 1'b0;
    wait_idle(500);
    check("t4_position_delta", position - pos0, 6);
    check("t4_step_cnt", step_cnt, 6);

    // pos_clr on the very cycle of the final step end
    d0 = done_cnt;
    setup_move(1'b1, 8, 1, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !pul_out; k++) tick();
    check("t5_pulse_seen", pul_out, 1);
    repeat (7) tick();
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_position", position, 0);
    check("t5_step_cnt", step_cnt, 1);
    check("t5_done_count", done_cnt - d0, 1);

    // short const period is clamped to PULSE_HI+1; brings position to 10
    setup_move(1'b1, 2, 10, 0, 0, 1'b1, 1'b1);
    check("t6_model_clamp", exp_per[0], 5);
    wait_idle(500);
    check("t6_cur_period", cur_period, 5);
    check("t6_position", position, 10);

    // abort while step 4 is high, moving backwards
    d0 = done_cnt;
    setup_move(1'b1, 10, 6, 0, 0, 1'b0, 1'b1);
    wait_rises(4, 200);
    check("t7_pul_high", pul_out, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_pul_low", pul_out, 0);
    check("t7_busy", busy, 0);
    check("t7_no_done", done, 0);
    repeat (5) tick();
    check("t7_done_count", done_cnt - d0, 0);
    check("t7_position", position, 7);
    check("t7_step_cnt", step_cnt, 3);
    check("t7_rises", rises, 4);

    // zero-length move: done next cycle, never busy
    d0 = done_cnt;
    total_steps = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t8_done", done, 1);
    check("t8_busy", busy, 0);
    tick();
    check("t8_done_clear", done, 0);
    check("t8_busy_after", busy, 0);
    check("t8_done_count", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
